inst_mem_sync: RTL and testbench

- Parametrised, registered-read instruction memory for the ARM pipeline IF stage.
- Replaces the fixed combinational instruction ROM. Adds:
  - a valid/ready fetch handshake with 1-cycle latency;
  - a runtime programming (loader) port;
  - hardware clear-to-NOP after reset;
  - misalignment and out-of-range detection;
  - pipeline freeze support.
- Byte-addressed, word-aligned, one instruction word per access.

---
 rtl/inst_mem_sync.sv | 104 ++++++++++
 tb/tb_inst_mem_sync.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_sync.sv
// Registered-read instruction memory for the IF stage. It provides a fetch handshake,
// a loader port, clear-to-NOP after reset, and error flags for misaligned or out-of-range addresses.
module inst_mem_sync #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 1024,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  req_idx, prog_idx;
  logic              req_bad, prog_bad;
  logic              accept, prog_en;

  // An address is bad if it is not word aligned or if it has any bit set above the index field.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  assign req_idx  = req_addr[IDX_W+1:2];
  assign prog_idx = prog_addr[IDX_W+1:2];
  assign req_bad  = addr_bad(req_addr);
  assign prog_bad = addr_bad(prog_addr);
  assign accept   = req_valid & req_ready;
  assign prog_en  = (state == RUN) & prog_we & ~prog_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_IDX) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    init_done = (state == RUN);
    req_ready = (state == RUN) & ~freeze;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
  end

  // The clear sweep owns the write port while in CLEAR, so loader writes are only honoured in RUN.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_cnt[IDX_W-1:0]] <= NOP_WORD;
    else if (prog_en)    mem[prog_idx] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prog_ack <= 1'b0;
    else      prog_ack <= prog_en;
  end

  // Freeze holds every response register, so a response seen while stalled is the same response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= NOP_WORD;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else if (state == RUN && !freeze) begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_addr <= req_addr;
        rsp_err  <= req_bad;
        rsp_inst <= req_bad ? NOP_WORD : mem[req_idx];
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync (DEPTH=16). Expected fetch responses are queued by the
// stimulus and popped by a monitor each time the DUT presents a fresh response.
module tb_inst_mem_sync;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              freeze = 1'b0;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_inst;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic              prog_ack;
  logic              init_done;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  inst_mem_sync #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_ack(prog_ack), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic we,
                               input logic [31:0] pa, input logic [31:0] pd, input logic frz);
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    prog_we   = we;
    prog_addr = pa;
    prog_data = pd;
    freeze    = frz;
  endtask

  task automatic expectRsp(input logic [31:0] inst, input logic [31:0] addr, input logic err);
    rsp_t r;
    r.inst = inst;
    r.addr = addr;
    r.err  = err;
    exp_q.push_back(r);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Sweep through the clear phase: init_done rises on exactly the DEPTH-th edge after release.
  task automatic clearPhase(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      afterEdge();
      if (i < DEPTH) begin
        checkOutput({tag, "_init_low"}, {31'b0, init_done}, 32'd0);
        checkOutput({tag, "_ready_low"}, {31'b0, req_ready}, 32'd0);
      end else begin
        checkOutput({tag, "_init_high"}, {31'b0, init_done}, 32'd1);
        checkOutput({tag, "_ready_high"}, {31'b0, req_ready}, 32'd1);
      end
      checkOutput({tag, "_no_ack_clear"}, {31'b0, prog_ack}, 32'd0);
    end
  endtask

  // Monitor: a response is new only when the edge that produced it was not frozen.
  always @(posedge clk) begin
    logic frz_at_edge;
    rsp_t e;
    frz_at_edge = freeze;
    #1;
    if (rst && rsp_valid && !frz_at_edge) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp_addr", rsp_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rsp_inst", rsp_inst, e.inst);
        checkOutput("rsp_addr", rsp_addr, e.addr);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    afterEdge();
    afterEdge();
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_prog_ack", {31'b0, prog_ack}, 32'd0);
    checkOutput("rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("rst_rsp_inst", rsp_inst, 32'h0);
    checkOutput("rst_rsp_addr", rsp_addr, 32'h0);

    // Release reset; a loader write held during clear must be ignored
    @(negedge clk);
    rst = 1'b1;
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hDEAD_BEEF;
    clearPhase("clr1");
    idle();

    // Fetch 0x0 from cleared memory, and 0x8 to confirm the clear-time write was dropped
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h8, 1'b0);
    idle();

    // Program word 0, ack pulses for exactly one cycle, then fetch it back
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 32'hE3A0_2103, 1'b0);
    afterEdge();
    checkOutput("prog_ack_pulse", {31'b0, prog_ack}, 32'd1);
    idle();
    afterEdge();
    checkOutput("prog_ack_drop", {31'b0, prog_ack}, 32'd0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'hE3A0_2103, 32'h0, 1'b0);

    // Misaligned and out-of-range fetches return NOP with the error flag
    applyStimulus(1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h6, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h40, 1'b1);

    // Bad loader addresses are dropped without an ack and leave word 0 intact
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h41, 32'h1111_1111, 1'b0);
    afterEdge();
    checkOutput("bad_prog_41_ack", {31'b0, prog_ack}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'h1234_5678, 1'b0);
    afterEdge();
    checkOutput("bad_prog_40_ack", {31'b0, prog_ack}, 32'd0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'hE3A0_2103, 32'h0, 1'b0);

    // Back-to-back fetches with a freeze after the 0x4 accept
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'hE3A0_2103, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h4, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("frz_ready_low", {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      afterEdge();
      checkOutput("frz_hold_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("frz_hold_addr", rsp_addr, 32'h4);
      checkOutput("frz_hold_inst", rsp_inst, 32'h0);
    end
    applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h8, 1'b0);
    #1;
    checkOutput("unfrz_ready", {31'b0, req_ready}, 32'd1);
    idle();
    afterEdge();
    checkOutput("idle_valid_low", {31'b0, rsp_valid}, 32'd0);
    checkOutput("idle_addr_hold", rsp_addr, 32'h8);

    // Same-cycle write and fetch of word 1: old data first, new data on refetch
    applyStimulus(1'b1, 32'h4, 1'b1, 32'h4, 32'hE490_2003, 1'b0);
    expectRsp(32'h0, 32'h4, 1'b0);
    afterEdge();
    checkOutput("rbw_prog_ack", {31'b0, prog_ack}, 32'd1);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'hE490_2003, 32'h4, 1'b0);

    // Reset in RUN while a response is showing and another fetch is pending
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rerst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rerst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("rerst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rerst_rsp_inst", rsp_inst, 32'h0);
    checkOutput("rerst_rsp_addr", rsp_addr, 32'h0);
    idle();
    afterEdge();
    @(negedge clk);
    rst = 1'b1;
    clearPhase("clr2");

    // Memory is back to NOP after the re-clear
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    expectRsp(32'h0, 32'h4, 1'b0);
    idle();
    repeat (3) afterEdge();

    checkOutput("scoreboard_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
